// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Request strobes are pure decodes of the current state, so they drop in the cycle after a reset edge.
module cpu_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [15:0]         imem_rdata,
    output logic [15:0]         instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                reg_we,
    output logic                halted,
    output logic [2:0]          state,
    output logic [15:0]         retired
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_JUMP  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         retired_q, retired_d;
    logic [2:0]          opcode;

    assign opcode = instr_q[15:13];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                case (opcode)
                    OP_JUMP: begin
                        pc_d      = instr_q[PC_WIDTH-1:0];
                        retired_d = retired_q + 16'd1;
                        state_d   = S_FETCH;
                    end
                    OP_HALT: begin
                        retired_d = retired_q + 16'd1;
                        state_d   = S_HALT;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        retired_d = retired_q + 16'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retired_d = retired_q + 16'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            // Unused codes recover to FETCH without touching architectural state
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_WIDTH'(RESET_PC);
            instr_q   <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) && (opcode == OP_STORE);
    assign reg_we    = (state_q == S_WB);
    assign halted    = (state_q == S_HALT);
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer; the model walks each instruction through its phase
// sequence (fetch waits, decode, execute, memory waits, writeback) and predicts every output.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_we;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .reg_we(reg_we), .halted(halted), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [7:0]  exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_retired;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        imem_valid = 1'($urandom);
        imem_rdata = 16'($urandom);
        dmem_ready = 1'($urandom);
    endtask

    // Phase codes: 0 fetch, 1 decode, 2 execute, 3 mem, 4 writeback, 5 halt
    task automatic chk_cyc(input logic [2:0] st);
        chk("state",     32'(state),     32'(st));
        chk("imem_req",  32'(imem_req),  32'(st == 3'd0));
        chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
        chk("dmem_req",  32'(dmem_req),  32'(st == 3'd3));
        chk("dmem_we",   32'(dmem_we),   32'(st == 3'd3 && exp_instr[15:13] == 3'b100));
        chk("reg_we",    32'(reg_we),    32'(st == 3'd4));
        chk("halted",    32'(halted),    32'(st == 3'd5));
        chk("pc",        32'(pc),        32'(exp_pc));
        chk("instr",     32'(instr),     32'(exp_instr));
        chk("retired",   32'(retired),   32'(exp_retired));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        noise();
        step();
        step();
        exp_pc      = 8'h00;
        exp_instr   = 16'h0000;
        exp_retired = 16'h0000;
        rst_n      = 1'b1;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        chk_cyc(3'd0);
    endtask

    // fw/mw: wait cycles in fetch/mem; abort asserts reset in the first mem cycle
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input bit abort);
        logic [2:0] op;
        op = ins[15:13];
        for (int i = 0; i <= fw; i++) begin
            chk_cyc(3'd0);
            imem_valid = (i == fw);
            imem_rdata = (i == fw) ? ins : 16'($urandom);
            dmem_ready = 1'($urandom);
            step();
        end
        exp_pc    = exp_pc + 8'd1;
        exp_instr = ins;
        noise(); chk_cyc(3'd1); step();
        noise(); chk_cyc(3'd2); step();
        if (op == 3'b110) begin
            exp_pc = ins[7:0];
            exp_retired++;
            return;
        end
        if (op == 3'b111) begin
            exp_retired++;
            for (int k = 0; k < 4; k++) begin
                chk_cyc(3'd5);
                imem_valid = 1'b1;
                imem_rdata = 16'($urandom);
                dmem_ready = 1'b1;
                step();
            end
            chk_cyc(3'd5);
            return;
        end
        if (op == 3'b100 || op == 3'b101) begin
            for (int j = 0; j <= mw; j++) begin
                chk_cyc(3'd3);
                imem_valid = 1'($urandom);
                imem_rdata = 16'($urandom);
                if (abort) begin
                    rst_n      = 1'b0;
                    dmem_ready = 1'b1;
                    step();
                    exp_pc      = 8'h00;
                    exp_instr   = 16'h0000;
                    exp_retired = 16'h0000;
                    rst_n      = 1'b1;
                    imem_valid = 1'b0;
                    dmem_ready = 1'b0;
                    chk_cyc(3'd0);
                    return;
                end
                dmem_ready = (j == mw);
                step();
            end
            if (op == 3'b100) begin
                exp_retired++;
                return;
            end
        end
        noise(); chk_cyc(3'd4); step();
        exp_retired++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [15:0] ins;
        rst_n = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        dmem_ready = 1'b0;
        exp_pc = 8'h00; exp_instr = 16'h0000; exp_retired = 16'h0000;
        do_reset();

        run_instr(16'h0246, 0, 0, 1'b0);
        chk("alu_pc", 32'(pc), 32'h1);
        chk("alu_retired", 32'(retired), 32'h1);
        run_instr(16'h8000, 0, 3, 1'b0);
        chk("store_retired", 32'(retired), 32'h2);
        run_instr(16'hA000, 0, 0, 1'b0);
        run_instr(16'hC0FF, 1, 0, 1'b0);
        chk("jump_ff", 32'(imem_addr), 32'hFF);
        run_instr(16'h0001, 0, 0, 1'b0);
        chk("pc_wrap", 32'(pc), 32'h00);
        run_instr(16'hC05A, 0, 0, 1'b0);
        chk("jump_5a", 32'(imem_addr), 32'h5A);
        run_instr(16'hA123, 2, 4, 1'b1);
        run_instr(16'h1111, 0, 0, 1'b0);
        run_instr(16'hE000, 1, 0, 1'b0);
        do_reset();

        for (int n = 0; n < 120; n++) begin
            op  = 3'($urandom_range(0, 7));
            ins = {op, 13'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2),
                      (op[2:1] == 2'b10) && ($urandom_range(0, 9) == 0));
            if (op == 3'b111) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
